// File: rtl/simon_btn_encoder.sv
// ============================================================================
// simon_btn_encoder: synchronise, debounce and encode four push-buttons into
// a single-cycle btn_valid/btn_val stream for the Simon game FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simon_btn_encoder #(
    parameter int DB_CNT = 8,
    parameter int CNT_W  = 8
) (
    input  logic       clk_tick,
    input  logic       reset_n,
    input  logic [3:0] btn_raw,
    input  logic       enable,
    output logic       btn_valid,
    output logic [1:0] btn_val,
    output logic       multi_press,
    output logic [3:0] db_btn,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_MULTI = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DB_CNT - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    state_t           state_q;
    logic             btn_valid_q;
    logic [1:0]       btn_val_q;
    logic             multi_q;
    logic [1:0]       btn_idx;

    // A bit only flips after DB_CNT consecutive cycles disagreeing with it.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == C_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        btn_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (db_q[i]) begin
                btn_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk_tick or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_tick or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            btn_valid_q <= 1'b0;
            btn_val_q   <= 2'd0;
            multi_q     <= 1'b0;
        end else begin
            btn_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (db_q != 4'b0000) begin
                        if ($onehot(db_q)) begin
                            state_q <= S_HOLD;
                            if (enable) begin
                                btn_valid_q <= 1'b1;
                                btn_val_q   <= btn_idx;
                            end
                        end else begin
                            state_q <= S_MULTI;
                            multi_q <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (db_q == 4'b0000) begin
                        state_q <= S_IDLE;
                    end
                end
                S_MULTI: begin
                    if (db_q == 4'b0000) begin
                        state_q <= S_IDLE;
                        multi_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    multi_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_valid   = btn_valid_q;
    assign btn_val     = btn_val_q;
    assign multi_press = multi_q;
    assign db_btn      = db_q;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_simon_btn_encoder.sv
// ============================================================================
// tb_simon_btn_encoder: directed and randomised self-checking bench against a
// window-based behavioural model of the button encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simon_btn_encoder;

    localparam int DB = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic       enable;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic       multi_press;
    logic [3:0] db_btn;
    logic [1:0] state;

    simon_btn_encoder #(
        .DB_CNT(DB),
        .CNT_W (8)
    ) dut (
        .clk_tick   (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .enable     (enable),
        .btn_valid  (btn_valid),
        .btn_val    (btn_val),
        .multi_press(multi_press),
        .db_btn     (db_btn),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;
    int pulses     = 0;
    int last_pulse = 0;
    int tick_no    = 0;
    logic [3:0] db_or;

    // Reference model: raw samples history plus press-level bookkeeping.
    logic [3:0] hist [$];
    logic [3:0] m_db;
    int         m_mode;
    logic       m_valid;
    logic [1:0] m_val;
    logic       m_multi;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(4'b0000);
        m_db = 4'b0000; m_mode = 0; m_valid = 1'b0; m_val = 2'd0; m_multi = 1'b0;
    endtask

    task automatic model_step();
        int n;
        logic [3:0] nd;
        logic flip;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        n = $countones(m_db);
        case (m_mode)
            0: begin
                if (n == 1) begin
                    m_mode = 1;
                    if (enable) begin
                        m_valid = 1'b1;
                        for (int i = 0; i < 4; i++) if (m_db[i]) m_val = 2'(i);
                    end
                end else if (n >= 2) begin
                    m_mode = 2; m_multi = 1'b1;
                end
            end
            1: if (n == 0) m_mode = 0;
            default: if (n == 0) begin m_mode = 0; m_multi = 1'b0; end
        endcase
        // Synchronised value at this edge is the raw sample two edges back;
        // a bit flips once the last DB synchronised values all disagree.
        hist.push_back(btn_raw);
        nd = m_db;
        for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (hist[hist.size() - 3 - j][b] == m_db[b]) flip = 1'b0;
            end
            if (flip) nd[b] = ~m_db[b];
        end
        m_db = nd;
        while (hist.size() > DB + 2) void'(hist.pop_front());
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            failed_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("btn_valid",   {7'd0, btn_valid},   {7'd0, m_valid});
        chk("btn_val",     {6'd0, btn_val},     {6'd0, m_val});
        chk("multi_press", {7'd0, multi_press}, {7'd0, m_multi});
        chk("db_btn",      {4'd0, db_btn},      {4'd0, m_db});
        chk("state",       {6'd0, state},       8'(m_mode));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick_no++;
        check_all();
        db_or = db_or | db_btn;
        if (btn_valid === 1'b1) begin
            pulses++;
            last_pulse = tick_no;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic phase_start();
        pulses = 0; last_pulse = 0; tick_no = 0; db_or = 4'b0000;
    endtask

    initial begin
        reset_n = 1'b0; btn_raw = 4'b0000; enable = 1'b1;
        model_reset();
        run(3);

        // Reset release, idle
        reset_n = 1'b1;
        phase_start();
        run(50);
        chk("idle_pulses", 8'(pulses), 8'd0);

        // Clean hold of button 2
        phase_start();
        btn_raw = 4'b0100;
        run(20);
        chk("hold_pulses",  8'(pulses), 8'd1);
        chk("hold_latency", 8'(last_pulse), 8'(DB + 3));
        chk("hold_val",     {6'd0, btn_val}, 8'd2);
        chk("hold_state",   {6'd0, state}, 8'd1);
        btn_raw = 4'b0000;
        run(20);
        chk("release_pulses", 8'(pulses), 8'd1);
        chk("release_state",  {6'd0, state}, 8'd0);

        // Bouncing press of button 1
        phase_start();
        for (int r = 0; r < 2; r++) begin
            btn_raw = 4'b0010; run(3);
            btn_raw = 4'b0000; run(1);
        end
        btn_raw = 4'b0010; run(10);
        btn_raw = 4'b0000; run(20);
        chk("bounce_pulses", 8'(pulses), 8'd1);
        chk("bounce_val",    {6'd0, btn_val}, 8'd1);

        // Short glitch only
        phase_start();
        btn_raw = 4'b0010; run(3);
        btn_raw = 4'b0000; run(20);
        chk("glitch_pulses", 8'(pulses), 8'd0);
        chk("glitch_db",     {4'd0, db_or}, 8'd0);

        // Simultaneous press of buttons 0 and 1
        phase_start();
        btn_raw = 4'b0011; run(20);
        chk("multi_pulses", 8'(pulses), 8'd0);
        chk("multi_flag",   {7'd0, multi_press}, 8'd1);
        chk("multi_state",  {6'd0, state}, 8'd2);
        btn_raw = 4'b0000; run(20);
        chk("multi_clr",    {7'd0, multi_press}, 8'd0);
        chk("multi_idle",   {6'd0, state}, 8'd0);
        btn_raw = 4'b1000; run(20);
        chk("after_multi_pulses", 8'(pulses), 8'd1);
        chk("after_multi_val",    {6'd0, btn_val}, 8'd3);
        btn_raw = 4'b0000; run(20);

        // Enable low swallows the press
        phase_start();
        enable = 1'b0; btn_raw = 4'b0001; run(20);
        chk("en_low_pulses", 8'(pulses), 8'd0);
        chk("en_low_state",  {6'd0, state}, 8'd1);
        enable = 1'b1; run(10);
        chk("en_rise_pulses", 8'(pulses), 8'd0);
        btn_raw = 4'b0000; run(20);
        btn_raw = 4'b0001; run(20);
        chk("en_repress_pulses", 8'(pulses), 8'd1);
        chk("en_repress_val",    {6'd0, btn_val}, 8'd0);
        btn_raw = 4'b0000; run(20);

        // Reset while button 3 held
        btn_raw = 4'b1000; run(12);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_state", {6'd0, state}, 8'd0);
        @(negedge clk);
        run(2);
        phase_start();
        reset_n = 1'b1;
        run(20);
        chk("rst_hold_pulses",  8'(pulses), 8'd1);
        chk("rst_hold_latency", 8'(last_pulse), 8'(DB + 3));
        chk("rst_hold_val",     {6'd0, btn_val}, 8'd3);
        btn_raw = 4'b0000; run(20);

        // Randomised segments
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 3))
                0:       btn_raw = 4'b0000;
                1, 2:    btn_raw = 4'(1 << $urandom_range(0, 3));
                default: btn_raw = 4'($urandom_range(0, 15));
            endcase
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 24) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check_all();
                @(negedge clk);
                run(2);
                reset_n = 1'b1;
            end
            run($urandom_range(1, 14));
        end
        btn_raw = 4'b0000;
        run(20);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simon_btn_encoder.md
Name: simon_btn_encoder

Overview:
- Front-end producer for the Simon game FSM's button interface; it generates the `btn_valid`/`btn_val` stream that the FSM consumes.
- Takes four raw, asynchronous, bouncing push-buttons, synchronises and debounces each one, and encodes them.
- Emits exactly one single-cycle `btn_valid` pulse with the 2-bit button index per clean single-button press.
- Rejects simultaneous presses and requires a full release before the next press is accepted.

Parameters:
- DB_CNT, default 8: consecutive stable cycles a synchronised input must hold a new level before the debounced bit changes (legal range 2..255).
- CNT_W, default 8: width of each per-button debounce counter; must satisfy 2^CNT_W > DB_CNT.

Ports:
- clk_tick  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  4  raw buttons, active-high; bit i is button i.
- enable  input  1  when low, clean presses are swallowed and produce no pulse.
- btn_valid  output  1  one-cycle pulse marking a clean press.
- btn_val  output  2  index of the pressed button; holds its value between pulses.
- multi_press  output  1  high while a multi-button press is held.
- db_btn  output  4  debounced button vector (debug).
- state  output  2  FSM state (debug): 0=S_IDLE, 1=S_HOLD, 2=S_MULTI.

Behaviour:
- Reset (async assert, sync deassert by design):
  - sync registers = 0, db_btn = 0, all counters = 0, state = S_IDLE.
  - btn_valid = 0, btn_val = 0, multi_press = 0.
- Synchroniser: 2-flop chain per bit (sync1 → sync2); only sync2 is used downstream.
- Debounce, per bit i, independently:
  - If sync2[i] == db_btn[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DB_CNT-1: db_btn[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i] + 1.
  - A mismatch lasting fewer than DB_CNT cycles never changes db_btn.
  - Press and release are filtered identically.
- FSM, evaluated on the registered db_btn:
  - S_IDLE:
    - db_btn == 0: stay.
    - db_btn one-hot: → S_HOLD. If enable=1, next cycle btn_valid=1 and btn_val=index; if enable=0, no pulse.
    - db_btn with ≥2 bits set: → S_MULTI, and multi_press=1 from the next cycle. No pulse.
  - S_HOLD:
    - Stays until db_btn == 0, then → S_IDLE.
    - Extra buttons appearing here are ignored: no pulse, multi_press unchanged.
  - S_MULTI:
    - multi_press stays 1.
    - When db_btn == 0: → S_IDLE and multi_press=0 on the same edge.
- Pulse rules:
  - btn_valid is registered and high for exactly one cycle per accepted press.
  - There is never a pulse while held, on release, or on re-entry of S_IDLE without a new press.
- Latency:
  - Let edge k be the first rising edge at which btn_raw is sampled high and then stays stable.
  - db_btn rises at edge k+DB_CNT+1.
  - btn_valid is high for the cycle following edge k+DB_CNT+2.
  - Release: db_btn clears at edge k'+DB_CNT+1, where k' is the first edge sampling the release.
  - The earliest next press may be accepted at the edge after db_btn clears.
- Simultaneous one-hot transition and enable falling in the same cycle: the enable value sampled on that edge decides.
- Buttons debouncing in the same cycle, so that db_btn jumps from 0 to multi-bit: treated as a multi-press.
- Reset mid-press:
  - All state is cleared.
  - A button still held after reset_n rises is re-debounced and produces a new pulse, after the full latency, if enable=1.
- btn_val is updated only on accepted pulses.

Test Plan (DB_CNT=4):
- Reset with btn_raw=0, then release reset -> all outputs 0, state=0, no btn_valid for 50 cycles.
- Clean hold of btn_raw=4'b0100 for 20 cycles, enable=1 -> single btn_valid pulse exactly 6 edges after the first sampling edge (DB_CNT+2), btn_val=2, state=1; after release, state returns to 0 with no second pulse.
- Bounce: btn_raw[1] toggles high for 3 cycles and low for 1 cycle, twice, then stays high 10 cycles -> exactly one pulse, btn_val=1; the 3-cycle glitch alone (no steady hold) -> no pulse and db_btn stays 0.
- Multi-press: btn_raw=4'b0011 asserted together and held 20 cycles -> no pulse, multi_press=1, state=2; on release, multi_press=0 and state=0; a following press of button 3 -> btn_val=3 pulse.
- Enable low: hold button 0 with enable=0 -> no pulse, state=1; raise enable while still held -> still no pulse; release then re-press -> pulse with btn_val=0.
- Reset mid-hold: button 3 held, assert reset_n=0 for 2 cycles while in S_HOLD -> outputs cleared immediately; after reset_n rises, one pulse with btn_val=3 after DB_CNT+2 edges.
